// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serial_adder
//  Purpose  : Adds two operands presented LSB-first, one bit pair per clock.
//             A carry flop links successive bits. Bits are framed into
//             WIDTH-bit words, and each result word is assembled in parallel
//             form and flagged with a one-cycle done pulse.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous reset, active-high
//             in_a       - operand A bit (LSB first)
//             in_b       - operand B bit (LSB first)
//             en         - consume in_a/in_b this cycle; 0 holds all state
//             start      - current bit is bit 0 of a new word (carry-in = 0)
//             sum        - registered sum bit of the last consumed pair
//             carry_out  - registered carry of the last consumed pair
//             sum_word   - parallel result word, valid when word_done = 1
//             word_done  - one-cycle pulse on completion of a full word
//  Revision : 1.0 - initial release
// ============================================================================
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             en,
  input  logic             start,
  output logic             sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_word,
  output logic             word_done
);

  // WIDTH >= 2, so the bit index always needs at least one bit.
  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] c_zero = '0;
  localparam logic [CW-1:0] c_one  = CW'(1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;       // index of the next bit within the word
  logic             r_sum;
  logic             r_cout;
  logic [WIDTH-1:0] r_sum_word;
  logic             r_done;

  logic             w_cin;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;

  // A new word starts either explicitly (start) or implicitly after the
  // previous word wrapped the index back to zero; either way the carry from
  // the previous bit must not leak into bit 0.
  assign w_cin  = (start || (r_cnt == c_zero)) ? 1'b0 : r_cout;
  assign w_sum  = in_a ^ in_b ^ w_cin;
  assign w_cout = (in_a & in_b) | (in_a & w_cin) | (in_b & w_cin);

  // start on the final index aborts that word, so it never completes it.
  assign w_last = ~start && (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= c_zero;
      r_sum      <= 1'b0;
      r_cout     <= 1'b0;
      r_sum_word <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en) begin
        r_sum      <= w_sum;
        r_cout     <= w_cout;
        // LSB-first fill: after WIDTH shifts bit 0 has reached position 0.
        r_sum_word <= {w_sum, r_sum_word[WIDTH-1:1]};
        r_done     <= w_last;
        if (start) begin
          r_cnt <= c_one;
        end else if (r_cnt == c_last) begin
          r_cnt <= c_zero;
        end else begin
          r_cnt <= r_cnt + c_one;
        end
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign sum_word  = r_sum_word;
  assign word_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serial_adder
//  Purpose  : Self-checking bench for bit_serial_adder (WIDTH = 8). A
//             word-level arithmetic model accumulates the operand bits seen
//             so far in the current word and derives each sum/carry bit from
//             the integer sum of those partial operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_a = 1'b0;
  logic             in_b = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic             sum;
  logic             carry_out;
  logic [WIDTH-1:0] sum_word;
  logic             word_done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int               m_idx;       // bits already consumed in the current word
  logic [31:0]      m_a, m_b;    // operand bits of the current word so far
  logic             m_sum, m_cout, m_done;
  logic [WIDTH-1:0] m_sw;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .en        (en),
    .start     (start),
    .sum       (sum),
    .carry_out (carry_out),
    .sum_word  (sum_word),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_idx = 0; m_a = '0; m_b = '0;
    m_sum = 1'b0; m_cout = 1'b0; m_done = 1'b0; m_sw = '0;
  endtask

  task automatic model_step(input logic a, input logic b, input logic e, input logic s);
    logic [31:0] tot;
    int k;
    m_done = 1'b0;
    if (e) begin
      if (s || m_idx == 0) begin
        m_a = '0; m_b = '0; k = 0;
      end else begin
        k = m_idx;
      end
      m_a[k] = a;
      m_b[k] = b;
      tot    = m_a + m_b;
      m_sum  = tot[k];
      m_cout = tot[k+1];
      m_sw   = {m_sum, m_sw[WIDTH-1:1]};
      m_idx  = k + 1;
      if (m_idx == WIDTH) begin
        m_done = 1'b1;
        m_idx  = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, let the DUT and the model see the same edge,
  // then return 1 time unit after the edge with outputs settled.
  task automatic step(input logic a, input logic b, input logic e, input logic s);
    @(negedge clk);
    in_a = a; in_b = b; en = e; start = s;
    @(posedge clk);
    model_step(a, b, e, s);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({sum, carry_out, word_done, sum_word} !== {1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      errors++;
      $display("FAIL reset_async: got sum=%b c=%b done=%b word=%h, want all zero",
               sum, carry_out, word_done, sum_word);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_bits();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      step(ab[1], ab[0], 1'b1, 1'b1);
      checks++;
      if ({sum, carry_out} !== {ab[1] ^ ab[0], ab[1] & ab[0]}) begin
        errors++;
        $display("FAIL single_bit a=%b b=%b: got sum=%b c=%b, want sum=%b c=%b",
                 ab[1], ab[0], sum, carry_out, ab[1] ^ ab[0], ab[1] & ab[0]);
      end
    end
  endtask

  task automatic test_carry_chain();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({sum, carry_out} !== 2'b01) begin
      errors++;
      $display("FAIL carry_edge1: got sum=%b c=%b, want sum=0 c=1", sum, carry_out);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({sum, carry_out} !== 2'b11) begin
      errors++;
      $display("FAIL carry_edge2: got sum=%b c=%b, want sum=1 c=1", sum, carry_out);
    end
  endtask

  task automatic test_words();
    logic [WIDTH-1:0] va [2];
    logic [WIDTH-1:0] vb [2];
    logic [WIDTH-1:0] ew [2];
    logic             ec [2];
    va[0] = 8'h5A; vb[0] = 8'h3C; ew[0] = 8'h96; ec[0] = 1'b0;
    va[1] = 8'hFF; vb[1] = 8'h01; ew[1] = 8'h00; ec[1] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < WIDTH; i++) begin
        step(va[w][i], vb[w][i], 1'b1, i == 0);
        checks++;
        if (word_done !== (i == WIDTH - 1)) begin
          errors++;
          $display("FAIL word%0d_done bit%0d: got %b, want %b", w, i, word_done, i == WIDTH - 1);
        end
      end
      checks++;
      if ({sum_word, carry_out} !== {ew[w], ec[w]}) begin
        errors++;
        $display("FAIL word%0d_result: got word=%h c=%b, want word=%h c=%b",
                 w, sum_word, carry_out, ew[w], ec[w]);
      end
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] a, b, snap_w;
    logic             snap_s, snap_c;
    logic [WIDTH:0]   tot;
    a = 8'hB7; b = 8'h6D;
    tot = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < 3; i++) step(a[i], b[i], 1'b1, i == 0);
    snap_s = sum; snap_c = carry_out; snap_w = sum_word;
    for (int i = 0; i < 3; i++) begin
      step(1'(i), ~1'(i), 1'b0, 1'(i));
      checks++;
      if ({sum, carry_out, word_done, sum_word} !== {snap_s, snap_c, 1'b0, snap_w}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got sum=%b c=%b done=%b word=%h, want %b %b 0 %h",
                 i, sum, carry_out, word_done, sum_word, snap_s, snap_c, snap_w);
      end
    end
    for (int i = 3; i < WIDTH; i++) step(a[i], b[i], 1'b1, 1'b0);
    checks++;
    if ({word_done, carry_out, sum_word} !== {1'b1, tot}) begin
      errors++;
      $display("FAIL hold_resume: got done=%b c=%b word=%h, want done=1 c=%b word=%h",
               word_done, carry_out, sum_word, tot[WIDTH], tot[WIDTH-1:0]);
    end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   tot;
    int               seen;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, i == 0);
      if (word_done) seen++;
    end
    a = 8'h9E; b = 8'hC3;
    tot = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < WIDTH; i++) begin
      step(a[i], b[i], 1'b1, i == 0);
      if (word_done && i != WIDTH - 1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d early done pulses, want 0", seen);
    end
    checks++;
    if ({word_done, carry_out, sum_word} !== {1'b1, tot}) begin
      errors++;
      $display("FAIL abort_new_word: got done=%b c=%b word=%h, want done=1 c=%b word=%h",
               word_done, carry_out, sum_word, tot[WIDTH], tot[WIDTH-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    a = 8'hFF; b = 8'h01;
    for (int i = 0; i < WIDTH; i++) step(a[i], b[i], 1'b1, i == 0);
    checks++;
    if ({word_done, carry_out, sum_word} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL b2b_first: got done=%b c=%b word=%h, want done=1 c=1 word=00",
               word_done, carry_out, sum_word);
    end
    // No start here: the overflow carry of the previous word must not enter bit 0.
    a = 8'h01; b = 8'h00;
    for (int i = 0; i < WIDTH; i++) step(a[i], b[i], 1'b1, 1'b0);
    checks++;
    if ({word_done, carry_out, sum_word} !== {1'b1, 1'b0, 8'h01}) begin
      errors++;
      $display("FAIL b2b_second: got done=%b c=%b word=%h, want done=1 c=0 word=01",
               word_done, carry_out, sum_word);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 1'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
      checks++;
      if ({sum, carry_out, word_done, sum_word} !== {m_sum, m_cout, m_done, m_sw}) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_step%0d: got sum=%b c=%b done=%b word=%h, want %b %b %b %h",
                   n, sum, carry_out, word_done, sum_word, m_sum, m_cout, m_done, m_sw);
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_bits();
    test_carry_chain();
    test_words();
    test_hold();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
